dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU MEM stage (port 0) and a DMA/boot-loader engine (port 1).
- CPU has fixed priority. A starvation counter forces a DMA grant after STARVE_MAX consecutive conflicts; on that cycle the CPU is stalled for exactly one cycle.
- Memory access is single-cycle: address, write data and write enable are presented combinationally, the write occurs at posedge, and read data returns combinationally the same cycle.

Parameters:
- STARVE_MAX, 4: consecutive conflict cycles won by the CPU before the DMA is forced through (0..255); 0 means DMA wins every conflict.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- cpu_req  in  1  CPU access this cycle (MemRead|MemWrite)
- cpu_we  in  1  CPU write when 1, read when 0
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data, combinational
- cpu_stall  out  1  CPU must freeze IF..MEM and re-present the same request next cycle
- dma_req  in  1  DMA access request; held stable until granted
- dma_we  in  1  DMA write when 1
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rdata  out  DATA_W  registered DMA read data
- dma_rvalid  out  1  one-cycle pulse, dma_rdata valid
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_rdata  in  DATA_W  from data memory

Behaviour:
- Internal state:
  - starve_cnt: 8 bits.
  - dma_rd_pend: 1 bit, a DMA read was granted last cycle.
- Grant decision (combinational, from current inputs and starve_cnt):
  - Neither request: no grant; mem_read=mem_write=0; mem_addr/mem_wdata=0.
  - cpu_req only: CPU owns the memory; cpu_stall=0.
  - dma_req only: DMA owns the memory; dma_gnt=1.
  - Both, starve_cnt < STARVE_MAX: CPU owns the memory; dma_gnt=0; cpu_stall=0.
  - Both, starve_cnt >= STARVE_MAX: DMA owns the memory; dma_gnt=1; cpu_stall=1.
- Owner drives the memory port: mem_addr, mem_wdata, mem_write=we, mem_read=~we.
- cpu_rdata = mem_rdata when the CPU owns the memory and reads; otherwise 0.
- starve_cnt update at posedge:
  - Conflict won by CPU: increment, saturating at 255.
  - DMA granted, or dma_req=0: cleared to 0.
  - Neither request while dma_req=1 is impossible.
- Stall bound:
  - After a forced DMA grant, starve_cnt=0, so the CPU's re-presented request wins next cycle.
  - cpu_stall never asserts on two consecutive cycles, except when STARVE_MAX=0 (stall lasts as long as dma_req stays high).
- DMA read path:
  - Granted DMA read: dma_rdata <= mem_rdata at that posedge; dma_rvalid=1 for the following cycle only.
  - DMA write: no dma_rvalid.
  - Back-to-back DMA reads give back-to-back rvalid pulses with updated data.
  - dma_rdata holds its value when no new read completes.
- Reset:
  - All registers cleared: starve_cnt=0, dma_rdata=0, dma_rvalid=0.
  - While reset=1, dma_gnt, cpu_stall, mem_read and mem_write are forced to 0, so no write is issued during reset.
  - Reset mid-operation: a pending rvalid pulse is dropped, and a DMA request granted in that cycle is not performed.
- DMA must not change dma_addr/dma_we/dma_wdata while dma_req=1 and dma_gnt=0. Behaviour on violation is undefined; the bench flags it.
- Latencies:
  - CPU access: 0 cycles, or 1 extra cycle when stalled.
  - DMA access: granted within STARVE_MAX+1 cycles of dma_req.
  - DMA read data: 1 cycle after grant.

Test Plan:
- Reset asserted mid-cycle with dma_req=1, dma_we=1 → mem_write=0, dma_gnt=0, all outputs 0.
- cpu_req=1 read addr 0x40 alone, memory returns 0x1234 → cpu_rdata=0x1234 same cycle, cpu_stall=0.
- dma_req=1 read addr 0x80 alone, memory returns 0xBEEF → dma_gnt=1 that cycle; next cycle dma_rvalid=1 and dma_rdata=0xBEEF.
- Both requests held continuously, STARVE_MAX=4 → CPU wins 4 cycles; cycle 5 dma_gnt=1 and cpu_stall=1; cycle 6 CPU wins, cpu_stall=0; pattern repeats every 5 cycles.
- STARVE_MAX=0, both requests for 3 cycles (DMA writes 0x10,0x14,0x18) → dma_gnt=1 and cpu_stall=1 on all 3 cycles; CPU granted the cycle dma_req drops.
- Conflict with starve_cnt=3, dma_req drops for 1 cycle then returns → counter resets; DMA waits a full 4 CPU-won conflicts again before being granted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU MEM stage has fixed priority over a DMA/boot-loader engine,
// and a starvation counter forces one DMA grant after STARVE_MAX consecutive lost conflicts.
module dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]        starve_cnt;
    logic              dma_rd_pend;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              conflict;
    logic              starved;
    logic              dma_own;
    logic              cpu_own;

    // Ownership is gated by reset so nothing reaches the memory while reset is held.
    always_comb begin
        conflict  = cpu_req & dma_req;
        starved   = (starve_cnt >= STARVE_LIM);
        dma_own   = ~reset & dma_req & (~cpu_req | starved);
        cpu_own   = ~reset & cpu_req & ~dma_own;

        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (dma_own) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_read  = ~dma_we;
            mem_write = dma_we;
        end else if (cpu_own) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
        end

        dma_gnt   = dma_own;
        cpu_stall = dma_own & cpu_req;
        cpu_rdata = (cpu_own & ~cpu_we) ? mem_rdata : '0;
    end

    // The counter only survives a cycle in which the CPU beat a waiting DMA request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt  <= 8'd0;
            dma_rd_pend <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            if (conflict & ~dma_own) begin
                if (starve_cnt != 8'hFF) begin
                    starve_cnt <= starve_cnt + 8'd1;
                end
            end else begin
                starve_cnt <= 8'd0;
            end
            dma_rd_pend <= dma_own & ~dma_we;
            if (dma_own & ~dma_we) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign dma_rvalid = dma_rd_pend;
    assign dma_rdata  = dma_rdata_q;

endmodule
